// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared state type and arbitration helpers for the TX TLP arbiter.
package tx_arb_pkg;

    typedef enum logic {IDLE, BUSY} state_t;

    // Round-robin pick over up to 8 requesters, searching upward from ptr with wrap mod n.
    function automatic logic [7:0] rr_pick(input logic [7:0] vld, input logic [2:0] ptr, input int n);
        logic [7:0] pick;
        logic [2:0] idx;
        pick = '0;
        for (int k = 0; k < n; k++) begin
            idx = 3'((int'(ptr) + k) % n);
            if (pick == '0 && vld[idx]) pick[idx] = 1'b1;
        end
        return pick;
    endfunction

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int k = 0; k < 8; k++) if (oh[k]) idx = idx | 3'(k);
        return idx;
    endfunction

endpackage

// File: rtl/tx_tlp_arbiter_gowin_if.sv
// tx_tlp_arbiter_gowin_if: requester-side and TX-side classic TLP stream signals of the arbiter.
interface tx_tlp_arbiter_gowin_if #(
    parameter int C_PCI_DATA_WIDTH = 256,
    parameter int C_NUM_REQ = 3,
    parameter int C_OFFSET_W = 3
);
    logic [C_NUM_REQ*C_PCI_DATA_WIDTH-1:0] REQ_TLP;
    logic [C_NUM_REQ-1:0] REQ_VALID;
    logic [C_NUM_REQ-1:0] REQ_START_FLAG;
    logic [C_NUM_REQ*C_OFFSET_W-1:0] REQ_START_OFFSET;
    logic [C_NUM_REQ-1:0] REQ_END_FLAG;
    logic [C_NUM_REQ*C_OFFSET_W-1:0] REQ_END_OFFSET;
    logic [C_NUM_REQ-1:0] REQ_READY;
    logic [C_PCI_DATA_WIDTH-1:0] TX_TLP;
    logic TX_TLP_VALID;
    logic TX_TLP_START_FLAG;
    logic [C_OFFSET_W-1:0] TX_TLP_START_OFFSET;
    logic TX_TLP_END_FLAG;
    logic [C_OFFSET_W-1:0] TX_TLP_END_OFFSET;
    logic TX_TLP_READY;
    logic [C_NUM_REQ-1:0] GRANT;
    logic [15:0] PKT_COUNT;
    logic PROTO_ERR;

    modport master (
        input REQ_TLP, REQ_VALID, REQ_START_FLAG, REQ_START_OFFSET, REQ_END_FLAG, REQ_END_OFFSET, TX_TLP_READY,
        output REQ_READY, TX_TLP, TX_TLP_VALID, TX_TLP_START_FLAG, TX_TLP_START_OFFSET, TX_TLP_END_FLAG,
        TX_TLP_END_OFFSET, GRANT, PKT_COUNT, PROTO_ERR
    );

    modport slave (
        output REQ_TLP, REQ_VALID, REQ_START_FLAG, REQ_START_OFFSET, REQ_END_FLAG, REQ_END_OFFSET, TX_TLP_READY,
        input REQ_READY, TX_TLP, TX_TLP_VALID, TX_TLP_START_FLAG, TX_TLP_START_OFFSET, TX_TLP_END_FLAG,
        TX_TLP_END_OFFSET, GRANT, PKT_COUNT, PROTO_ERR
    );

endinterface

// File: rtl/tx_arb_mux.sv
// tx_arb_mux: one-hot AND-OR payload mux; an all-zero select drives every output to 0.
module tx_arb_mux #(
    parameter int DW = 256,
    parameter int N = 3,
    parameter int OW = 3
) (
    input  logic [N-1:0] sel,
    input  logic [N*DW-1:0] req_tlp,
    input  logic [N-1:0] req_valid,
    input  logic [N-1:0] req_start_flag,
    input  logic [N*OW-1:0] req_start_offset,
    input  logic [N-1:0] req_end_flag,
    input  logic [N*OW-1:0] req_end_offset,
    output logic [DW-1:0] tlp,
    output logic valid,
    output logic start_flag,
    output logic [OW-1:0] start_offset,
    output logic end_flag,
    output logic [OW-1:0] end_offset
);

    assign valid = |(sel & req_valid);
    assign start_flag = |(sel & req_start_flag);
    assign end_flag = |(sel & req_end_flag);

    always_comb begin
        tlp = '0;
        start_offset = '0;
        end_offset = '0;
        for (int i = 0; i < N; i++) begin
            tlp = tlp | (req_tlp[i*DW +: DW] & {DW{sel[i]}});
            start_offset = start_offset | (req_start_offset[i*OW +: OW] & {OW{sel[i]}});
            end_offset = end_offset | (req_end_offset[i*OW +: OW] & {OW{sel[i]}});
        end
    end

endmodule

// File: rtl/tx_tlp_arbiter_gowin.sv
// tx_tlp_arbiter_gowin: packet-atomic round-robin arbiter sharing the TX classic TLP stream
// between C_NUM_REQ engines; counts forwarded TLPs and flags protocol errors.
module tx_tlp_arbiter_gowin
    import tx_arb_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 256,
    parameter int C_NUM_REQ = 3,
    parameter int C_OFFSET_W = 3
) (
    input logic CLK,
    input logic RST_IN,
    tx_tlp_arbiter_gowin_if.master bus
);

    state_t state, state_nxt;
    logic [C_NUM_REQ-1:0] grant, grant_nxt, win;
    logic [2:0] rr_ptr, rr_nxt, g;
    logic [15:0] pkt_count;
    logic mid, mid_nxt, err, err_nxt, acc, last, start;

    assign win = C_NUM_REQ'(rr_pick(8'(bus.REQ_VALID & bus.REQ_START_FLAG), rr_ptr, C_NUM_REQ));
    assign g = oh2idx(8'(grant));
    assign acc = (state == BUSY) & |(grant & bus.REQ_VALID) & bus.TX_TLP_READY;
    assign last = acc & |(grant & bus.REQ_END_FLAG);
    assign start = |(grant & bus.REQ_START_FLAG);

    always_ff @(posedge CLK or negedge RST_IN) begin
        if (!RST_IN) begin
            state <= IDLE;
            grant <= '0;
            rr_ptr <= '0;
            pkt_count <= '0;
            mid <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            rr_ptr <= rr_nxt;
            pkt_count <= pkt_count + 16'(last);
            mid <= mid_nxt;
            err <= err_nxt;
        end
    end

    // mid marks that the current packet already had a beat accepted, so a later START is illegal.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt = rr_ptr;
        mid_nxt = (state == BUSY) & (acc ? ~last : mid);
        err_nxt = err | ((state == IDLE) & |(bus.REQ_VALID & ~bus.REQ_START_FLAG)) | (acc & start & mid);
        if (state == IDLE && |win) begin
            state_nxt = BUSY;
            grant_nxt = win;
        end else if (last) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            rr_nxt = (32'(g) == C_NUM_REQ - 1) ? 3'd0 : g + 3'd1;
        end
    end

    assign bus.GRANT = grant;
    assign bus.REQ_READY = grant & {C_NUM_REQ{bus.TX_TLP_READY}};
    assign bus.PKT_COUNT = pkt_count;
    assign bus.PROTO_ERR = err;

    tx_arb_mux #(.DW(C_PCI_DATA_WIDTH), .N(C_NUM_REQ), .OW(C_OFFSET_W)) u_mux (
        .sel(grant),
        .req_tlp(bus.REQ_TLP),
        .req_valid(bus.REQ_VALID),
        .req_start_flag(bus.REQ_START_FLAG),
        .req_start_offset(bus.REQ_START_OFFSET),
        .req_end_flag(bus.REQ_END_FLAG),
        .req_end_offset(bus.REQ_END_OFFSET),
        .tlp(bus.TX_TLP),
        .valid(bus.TX_TLP_VALID),
        .start_flag(bus.TX_TLP_START_FLAG),
        .start_offset(bus.TX_TLP_START_OFFSET),
        .end_flag(bus.TX_TLP_END_FLAG),
        .end_offset(bus.TX_TLP_END_OFFSET)
    );

endmodule

// File: tb/tb_tx_tlp_arbiter_gowin.sv
// tb_tx_tlp_arbiter_gowin: directed scenario tests for the TX TLP round-robin arbiter.
module tb_tx_tlp_arbiter_gowin;

    localparam int DW = 256;
    localparam int N = 3;
    localparam int OW = 3;

    logic CLK = 1'b0;
    logic RST_IN = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    tx_tlp_arbiter_gowin_if #(.C_PCI_DATA_WIDTH(DW), .C_NUM_REQ(N), .C_OFFSET_W(OW)) bus ();

    tx_tlp_arbiter_gowin #(.C_PCI_DATA_WIDTH(DW), .C_NUM_REQ(N), .C_OFFSET_W(OW)) dut (
        .CLK(CLK),
        .RST_IN(RST_IN),
        .bus(bus)
    );

    function automatic logic [DW-1:0] pat(input int i, input int k);
        return DW'(32'hA000_0000 + i * 256 + k);
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic sf, input logic ef,
                         input logic [OW-1:0] so, input logic [OW-1:0] eo, input logic [DW-1:0] d);
        bus.REQ_VALID[i] = v;
        bus.REQ_START_FLAG[i] = sf;
        bus.REQ_END_FLAG[i] = ef;
        bus.REQ_START_OFFSET[i*OW +: OW] = so;
        bus.REQ_END_OFFSET[i*OW +: OW] = eo;
        bus.REQ_TLP[i*DW +: DW] = d;
    endtask

    task automatic clear_all;
        bus.REQ_VALID = '0;
        bus.REQ_START_FLAG = '0;
        bus.REQ_END_FLAG = '0;
        bus.REQ_START_OFFSET = '0;
        bus.REQ_END_OFFSET = '0;
        bus.REQ_TLP = '0;
    endtask

    task automatic do_reset;
        RST_IN = 1'b0;
        clear_all();
        bus.TX_TLP_READY = 1'b1;
        tick();
        RST_IN = 1'b1;
    endtask

    task automatic test_reset;
        RST_IN = 1'b0;
        bus.TX_TLP_READY = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b1, 3'd1, 3'd2, pat(0, 0));
        tick();
        tick();
        total++; if (bus.GRANT !== 3'b000) begin bad++; $display("FAIL reset_grant: got %b want 000", bus.GRANT); end
        total++; if (bus.TX_TLP_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.TX_TLP_VALID); end
        total++; if (bus.REQ_READY !== 3'b000) begin bad++; $display("FAIL reset_ready: got %b want 000", bus.REQ_READY); end
        total++; if (bus.PKT_COUNT !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.PKT_COUNT); end
        total++; if (bus.PROTO_ERR !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.PROTO_ERR); end
        total++; if (bus.TX_TLP !== '0) begin bad++; $display("FAIL reset_tlp: got %h want 0", bus.TX_TLP); end
        clear_all();
        RST_IN = 1'b1;
    endtask

    task automatic test_single_beat;
        do_reset();
        drive(1, 1'b1, 1'b1, 1'b1, 3'd0, 3'd3, pat(1, 0));
        #1;
        total++; if (bus.TX_TLP_VALID !== 1'b0) begin bad++; $display("FAIL single_idle_valid: got %b want 0", bus.TX_TLP_VALID); end
        tick();
        total++; if (bus.GRANT !== 3'b010) begin bad++; $display("FAIL single_grant: got %b want 010", bus.GRANT); end
        total++; if (bus.TX_TLP_VALID !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", bus.TX_TLP_VALID); end
        total++; if (bus.TX_TLP_END_OFFSET !== 3'd3) begin bad++; $display("FAIL single_eoff: got %0d want 3", bus.TX_TLP_END_OFFSET); end
        total++; if (bus.TX_TLP_START_OFFSET !== 3'd0) begin bad++; $display("FAIL single_soff: got %0d want 0", bus.TX_TLP_START_OFFSET); end
        total++; if (bus.TX_TLP !== pat(1, 0)) begin bad++; $display("FAIL single_data: got %h want %h", bus.TX_TLP, pat(1, 0)); end
        total++; if (bus.REQ_READY !== 3'b010) begin bad++; $display("FAIL single_ready: got %b want 010", bus.REQ_READY); end
        total++; if (bus.TX_TLP_START_FLAG !== 1'b1 || bus.TX_TLP_END_FLAG !== 1'b1) begin bad++; $display("FAIL single_flags: got %b%b want 11", bus.TX_TLP_START_FLAG, bus.TX_TLP_END_FLAG); end
        tick();
        clear_all();
        #1;
        total++; if (bus.GRANT !== 3'b000) begin bad++; $display("FAIL single_release: got %b want 000", bus.GRANT); end
        total++; if (bus.PKT_COUNT !== 16'd1) begin bad++; $display("FAIL single_count: got %0d want 1", bus.PKT_COUNT); end
        // pointer now 2, so a tie between req0 and req2 goes to req2
        drive(0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, pat(0, 0));
        drive(2, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, pat(2, 0));
        tick();
        total++; if (bus.GRANT !== 3'b100) begin bad++; $display("FAIL rr_ptr_tie: got %b want 100", bus.GRANT); end
        tick();
        drive(2, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, '0);
        tick();
        total++; if (bus.GRANT !== 3'b001) begin bad++; $display("FAIL rr_wrap: got %b want 001", bus.GRANT); end
        tick();
        clear_all();
        #1;
        total++; if (bus.PKT_COUNT !== 16'd3) begin bad++; $display("FAIL rr_count: got %0d want 3", bus.PKT_COUNT); end
    endtask

    task automatic test_back_to_back;
        int bt[N];
        int pk[N];
        int want[N];
        int done;
        logic [N-1:0] rdy;
        int cyc_log[$];
        logic [N-1:0] gnt_log[$];
        logic [DW-1:0] dat_log[$];
        int exp_cyc[8];
        logic [N-1:0] exp_gnt[8];
        int exp_own[8];
        int exp_k[8];
        exp_cyc = '{1, 2, 4, 5, 7, 8, 10, 11};
        exp_gnt = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
        exp_own = '{0, 0, 1, 1, 2, 2, 0, 0};
        exp_k = '{0, 1, 0, 1, 0, 1, 2, 3};
        want = '{2, 1, 1};
        bt = '{0, 0, 0};
        pk = '{0, 0, 0};
        done = 0;
        do_reset();
        for (int c = 0; c < 40 && done < 4; c++) begin
            for (int i = 0; i < N; i++)
                if (pk[i] < want[i]) drive(i, 1'b1, bt[i] == 0, bt[i] == 1, 3'd0, 3'd0, pat(i, pk[i] * 2 + bt[i]));
                else drive(i, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, '0);
            #1;
            if (bus.TX_TLP_VALID && bus.TX_TLP_READY) begin
                cyc_log.push_back(c);
                gnt_log.push_back(bus.GRANT);
                dat_log.push_back(bus.TX_TLP);
            end
            rdy = bus.REQ_READY;
            tick();
            for (int i = 0; i < N; i++)
                if (rdy[i]) begin
                    if (bt[i] == 1) begin
                        bt[i] = 0;
                        pk[i]++;
                        done++;
                    end else bt[i] = 1;
                end
        end
        clear_all();
        #1;
        total++; if (cyc_log.size() != 8) begin bad++; $display("FAIL b2b_beats: got %0d want 8", cyc_log.size()); end
        for (int j = 0; j < 8 && j < cyc_log.size(); j++) begin
            total++; if (cyc_log[j] != exp_cyc[j]) begin bad++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", j, cyc_log[j], exp_cyc[j]); end
            total++; if (gnt_log[j] !== exp_gnt[j]) begin bad++; $display("FAIL b2b_grant[%0d]: got %b want %b", j, gnt_log[j], exp_gnt[j]); end
            total++; if (dat_log[j] !== pat(exp_own[j], exp_k[j])) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", j, dat_log[j], pat(exp_own[j], exp_k[j])); end
        end
        total++; if (bus.PKT_COUNT !== 16'd4) begin bad++; $display("FAIL b2b_count: got %0d want 4", bus.PKT_COUNT); end
    endtask

    task automatic test_backpressure;
        do_reset();
        drive(0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, pat(0, 0));
        drive(2, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, pat(2, 0));
        tick();
        total++; if (bus.GRANT !== 3'b001) begin bad++; $display("FAIL bp_grant: got %b want 001", bus.GRANT); end
        total++; if (bus.TX_TLP !== pat(0, 0)) begin bad++; $display("FAIL bp_beat0: got %h want %h", bus.TX_TLP, pat(0, 0)); end
        tick();
        drive(0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd5, pat(0, 1));
        bus.TX_TLP_READY = 1'b0;
        repeat (5) begin
            #1;
            total++; if (bus.GRANT !== 3'b001) begin bad++; $display("FAIL bp_hold_grant: got %b want 001", bus.GRANT); end
            total++; if (bus.TX_TLP !== pat(0, 1)) begin bad++; $display("FAIL bp_hold_data: got %h want %h", bus.TX_TLP, pat(0, 1)); end
            total++; if (bus.REQ_READY !== 3'b000) begin bad++; $display("FAIL bp_hold_ready: got %b want 000", bus.REQ_READY); end
            total++; if (bus.TX_TLP_VALID !== 1'b1) begin bad++; $display("FAIL bp_hold_valid: got %b want 1", bus.TX_TLP_VALID); end
            tick();
        end
        bus.TX_TLP_READY = 1'b1;
        #1;
        total++; if (bus.REQ_READY !== 3'b001) begin bad++; $display("FAIL bp_release_ready: got %b want 001", bus.REQ_READY); end
        tick();
        drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, '0);
        #1;
        total++; if (bus.GRANT !== 3'b000) begin bad++; $display("FAIL bp_idle: got %b want 000", bus.GRANT); end
        total++; if (bus.PKT_COUNT !== 16'd1) begin bad++; $display("FAIL bp_count1: got %0d want 1", bus.PKT_COUNT); end
        tick();
        total++; if (bus.GRANT !== 3'b100) begin bad++; $display("FAIL bp_req2_grant: got %b want 100", bus.GRANT); end
        total++; if (bus.TX_TLP !== pat(2, 0)) begin bad++; $display("FAIL bp_req2_data: got %h want %h", bus.TX_TLP, pat(2, 0)); end
        tick();
        clear_all();
        #1;
        total++; if (bus.PKT_COUNT !== 16'd2) begin bad++; $display("FAIL bp_count2: got %0d want 2", bus.PKT_COUNT); end
    endtask

    task automatic test_proto_err;
        do_reset();
        total++; if (bus.PROTO_ERR !== 1'b0) begin bad++; $display("FAIL perr_clear: got %b want 0", bus.PROTO_ERR); end
        drive(2, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, pat(2, 9));
        drive(1, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, pat(1, 0));
        tick();
        total++; if (bus.PROTO_ERR !== 1'b1) begin bad++; $display("FAIL perr_idle_set: got %b want 1", bus.PROTO_ERR); end
        total++; if (bus.GRANT !== 3'b010) begin bad++; $display("FAIL perr_other_grant: got %b want 010", bus.GRANT); end
        tick();
        drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, '0);
        repeat (3) begin
            #1;
            total++; if (bus.GRANT !== 3'b000) begin bad++; $display("FAIL perr_no_grant: got %b want 000", bus.GRANT); end
            tick();
        end
        drive(0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, pat(0, 0));
        tick();
        total++; if (bus.GRANT !== 3'b001) begin bad++; $display("FAIL perr_req0_grant: got %b want 001", bus.GRANT); end
        total++; if (bus.TX_TLP !== pat(0, 0)) begin bad++; $display("FAIL perr_req0_data: got %h want %h", bus.TX_TLP, pat(0, 0)); end
        tick();
        clear_all();
        #1;
        total++; if (bus.PKT_COUNT !== 16'd2) begin bad++; $display("FAIL perr_count: got %0d want 2", bus.PKT_COUNT); end
        total++; if (bus.PROTO_ERR !== 1'b1) begin bad++; $display("FAIL perr_sticky: got %b want 1", bus.PROTO_ERR); end
        do_reset();
        total++; if (bus.PROTO_ERR !== 1'b0) begin bad++; $display("FAIL perr_reset: got %b want 0", bus.PROTO_ERR); end
        drive(0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, pat(0, 0));
        tick();
        tick();
        drive(0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, pat(0, 1));
        #1;
        total++; if (bus.PROTO_ERR !== 1'b0) begin bad++; $display("FAIL perr_first_ok: got %b want 0", bus.PROTO_ERR); end
        tick();
        clear_all();
        #1;
        total++; if (bus.PROTO_ERR !== 1'b1) begin bad++; $display("FAIL perr_mid_start: got %b want 1", bus.PROTO_ERR); end
        total++; if (bus.PKT_COUNT !== 16'd1) begin bad++; $display("FAIL perr_mid_count: got %0d want 1", bus.PKT_COUNT); end
    endtask

    task automatic test_reset_mid_packet;
        do_reset();
        drive(1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, pat(1, 0));
        tick();
        tick();
        drive(1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, pat(1, 1));
        #1;
        total++; if (bus.TX_TLP_VALID !== 1'b1) begin bad++; $display("FAIL rmid_beat2: got %b want 1", bus.TX_TLP_VALID); end
        RST_IN = 1'b0;
        #1;
        total++; if (bus.GRANT !== 3'b000) begin bad++; $display("FAIL rmid_grant: got %b want 000", bus.GRANT); end
        total++; if (bus.TX_TLP_VALID !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", bus.TX_TLP_VALID); end
        total++; if (bus.REQ_READY !== 3'b000) begin bad++; $display("FAIL rmid_ready: got %b want 000", bus.REQ_READY); end
        total++; if (bus.TX_TLP !== '0) begin bad++; $display("FAIL rmid_tlp: got %h want 0", bus.TX_TLP); end
        tick();
        tick();
        clear_all();
        RST_IN = 1'b1;
        drive(1, 1'b1, 1'b1, 1'b1, 3'd0, 3'd2, pat(1, 7));
        #1;
        total++; if (bus.GRANT !== 3'b000) begin bad++; $display("FAIL rmid_fresh_idle: got %b want 000", bus.GRANT); end
        tick();
        total++; if (bus.GRANT !== 3'b010) begin bad++; $display("FAIL rmid_fresh_grant: got %b want 010", bus.GRANT); end
        total++; if (bus.TX_TLP !== pat(1, 7)) begin bad++; $display("FAIL rmid_fresh_data: got %h want %h", bus.TX_TLP, pat(1, 7)); end
        tick();
        clear_all();
        #1;
        total++; if (bus.PKT_COUNT !== 16'd1) begin bad++; $display("FAIL rmid_count: got %0d want 1", bus.PKT_COUNT); end
    endtask

    // Preload the counter near the top so the wrap is reached without 65536 real packets.
    task automatic test_count_wrap;
        do_reset();
        force dut.pkt_count = 16'hFFFE;
        #1;
        release dut.pkt_count;
        #1;
        total++; if (bus.PKT_COUNT !== 16'hFFFE) begin bad++; $display("FAIL wrap_preload: got %h want fffe", bus.PKT_COUNT); end
        drive(0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, pat(0, 0));
        tick();
        tick();
        total++; if (bus.PKT_COUNT !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff: got %h want ffff", bus.PKT_COUNT); end
        tick();
        tick();
        clear_all();
        #1;
        total++; if (bus.PKT_COUNT !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h want 0000", bus.PKT_COUNT); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_all();
        bus.TX_TLP_READY = 1'b1;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_proto_err();
        test_reset_mid_packet();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_tlp_arbiter_gowin.md
Name: tx_tlp_arbiter_gowin

Overview:
- Packet-atomic round-robin arbiter that shares the single TX classic TLP stream between C_NUM_REQ engines (e.g. read-request, write, completion).
- Its output drives the TX classic input of the Gowin translation layer.
- Once granted, a requester owns the stream from its start-flag beat through its end-flag beat.
- Counts forwarded packets and flags protocol errors.

Parameters:
- C_PCI_DATA_WIDTH, 256, TLP beat width in bits.
- C_NUM_REQ, 3, number of requesters (2..8).
- C_OFFSET_W, 3, width of start/end offset fields, equal to clog2(C_PCI_DATA_WIDTH/32).

Ports:
- CLK  in  1  single clock.
- RST_IN  in  1  reset, active-low, asynchronous.
- REQ_TLP  in  C_NUM_REQ*C_PCI_DATA_WIDTH  requester beats; slice i belongs to requester i.
- REQ_VALID  in  C_NUM_REQ  beat valid, per requester.
- REQ_START_FLAG  in  C_NUM_REQ  first beat of a TLP.
- REQ_START_OFFSET  in  C_NUM_REQ*C_OFFSET_W  start offset, per requester.
- REQ_END_FLAG  in  C_NUM_REQ  last beat of a TLP.
- REQ_END_OFFSET  in  C_NUM_REQ*C_OFFSET_W  end offset, per requester.
- REQ_READY  out  C_NUM_REQ  beat accepted from requester i.
- TX_TLP  out  C_PCI_DATA_WIDTH  muxed beat.
- TX_TLP_VALID  out  1  muxed valid.
- TX_TLP_START_FLAG  out  1  muxed start flag.
- TX_TLP_START_OFFSET  out  C_OFFSET_W  muxed start offset.
- TX_TLP_END_FLAG  out  1  muxed end flag.
- TX_TLP_END_OFFSET  out  C_OFFSET_W  muxed end offset.
- TX_TLP_READY  in  1  downstream accept.
- GRANT  out  C_NUM_REQ  one-hot current owner; 0 when idle.
- PKT_COUNT  out  16  TLPs forwarded; wraps 0xFFFF->0.
- PROTO_ERR  out  1  sticky protocol-error flag.

Behaviour:
- Reset (RST_IN=0, async):
  - state=IDLE, GRANT=0, rr_ptr=0, PKT_COUNT=0, PROTO_ERR=0.
  - All TX_* outputs and REQ_READY are 0.
  - Reset mid-packet abandons the packet; no recovery beat is sent.
- States: IDLE, BUSY.
- IDLE:
  - Candidates are requesters with REQ_VALID[i] & REQ_START_FLAG[i].
  - Search starts at rr_ptr, ascending with wrap mod C_NUM_REQ; first candidate wins.
  - Next edge: GRANT<=onehot(winner), state<=BUSY.
  - No candidate: stay in IDLE.
  - TX_TLP_VALID=0 and REQ_READY=0 while in IDLE.
- BUSY:
  - All TX_* outputs are combinational muxes of the granted slice; TX_TLP_VALID=REQ_VALID[g].
  - REQ_READY[g]=TX_TLP_READY; every other REQ_READY bit is 0.
  - A beat is accepted when REQ_VALID[g] & TX_TLP_READY.
  - Accepted beat with END_FLAG: state<=IDLE, GRANT<=0, rr_ptr<=(g+1) mod C_NUM_REQ, PKT_COUNT<=PKT_COUNT+1.
  - Accepted single-beat TLP (START&END): one beat, then return to IDLE.
- Latency:
  - 1 cycle from an IDLE request to the first beat presented.
  - 1 bubble cycle between consecutive packets; this is intentional and keeps the mux off the arbitration path.
- Backpressure: TX_TLP_READY low holds the grant indefinitely; no timeout.
- A requester deasserting valid mid-packet holds the grant; the gap is passed through as TX_TLP_VALID=0.
- PROTO_ERR is set (sticky until reset) on either:
  - an accepted beat in BUSY with START_FLAG that is not the first beat of the packet;
  - REQ_VALID[i] & ~REQ_START_FLAG[i] while IDLE. Such requests are ignored and never granted.
- Simultaneous requests resolve by rr_ptr only. Starvation bound: C_NUM_REQ-1 packets.

Decomposition:
- Shared package tx_arb_pkg holds:
  - state enum {IDLE, BUSY};
  - function rr_pick(valid vector, pointer) returning a one-hot vector;
  - onehot-to-index function.
- One sub-module: tx_arb_mux, a one-hot-select payload mux for data, flags and offsets, instantiated once.

Test Plan:
- N=3; only req1 sends a 1-beat TLP with START_OFFSET=0, END_OFFSET=3 -> TX_TLP_VALID high 1 cycle after the request; TX_TLP_END_OFFSET=3; GRANT=3'b010; PKT_COUNT=1; rr_ptr=2.
- req0,req1,req2 each send 2-beat TLPs held continuously valid -> service order 0,1,2,0; exactly 1 idle cycle between packets; PKT_COUNT=4.
- req0 granted, TX_TLP_READY low for 5 cycles mid-packet -> GRANT stays 3'b001; TX_TLP stable; REQ_READY=0 for all requesters; req2 is not served until req0's end beat is accepted.
- Valid without start flag on req2 while IDLE -> PROTO_ERR=1, req2 never granted, other traffic unaffected.
- RST_IN low during beat 2 of a 4-beat TLP -> outputs 0 immediately; after release, a fresh TLP from req1 is granted normally.
- 65536 single-beat TLPs -> PKT_COUNT wraps to 0.
